// File: rtl/ascon_out_collector.sv
// ascon_out_collector
// Captures ASCON-128 ciphertext blocks into a small FIFO and the final tag into
// a holding register, then serializes ciphertext (high word first) followed by
// the tag onto a 32-bit valid/ready host stream. Sticky overflow flags any
// dropped block or tag.
module ascon_out_collector #(
    parameter int DEPTH = 4
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    input  logic [127:0] tag_i,
    input  logic         end_i,
    input  logic         ready_i,
    output logic [31:0]  data_o,
    output logic         valid_o,
    output logic         is_tag_o,
    output logic         last_o,
    output logic         overflow_o,
    output logic         busy_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CT_HI,
        S_CT_LO,
        S_TAG
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   widx;
    logic [1:0]   widx_next;

    logic [63:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push;
    logic         cipher_drop;
    logic [63:0]  head;

    logic         tag_pend;
    logic [127:0] tag_q;
    logic         tag_done;
    logic         tag_drop;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pop happens on the low-word transfer; a push into a full FIFO is allowed
    // when the head leaves on the same edge.
    assign pop         = (state == S_CT_LO) && ready_i;
    assign push        = cipher_valid_i && (!full || pop);
    assign cipher_drop = cipher_valid_i && full && !pop;

    assign tag_done = (state == S_TAG) && ready_i && (widx == 2'd3);
    assign tag_drop = end_i && tag_pend;

    assign busy_o = !empty || tag_pend || (state != S_IDLE);

    // FIFO storage write.
    // NOTE: the storage array is deliberately not reset; nothing reads it while
    // the FIFO is empty, and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cipher_i;
        end
    end

    // FIFO pointer update.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Tag capture; a second tag while one is still pending is dropped.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tag_pend <= 1'b0;
            tag_q    <= '0;
        end else if (end_i && !tag_pend) begin
            tag_pend <= 1'b1;
            tag_q    <= tag_i;
        end else if (tag_done) begin
            tag_pend <= 1'b0;
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle start clear.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
        end else if (cipher_drop || tag_drop) begin
            overflow_o <= 1'b1;
        end else if (start_i) begin
            overflow_o <= 1'b0;
        end
    end

    // Serializer state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
            widx  <= 2'd0;
        end else begin
            state <= state_next;
            widx  <= widx_next;
        end
    end

    // Serializer next state and output decode from registered state only.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        widx_next  = widx;
        data_o     = 32'd0;
        valid_o    = 1'b0;
        is_tag_o   = 1'b0;
        last_o     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_next = S_CT_HI;
                end else if (tag_pend) begin
                    state_next = S_TAG;
                    widx_next  = 2'd0;
                end
            end
            S_CT_HI: begin
                valid_o = 1'b1;
                data_o  = head[63:32];
                if (ready_i) state_next = S_CT_LO;
            end
            S_CT_LO: begin
                valid_o = 1'b1;
                data_o  = head[31:0];
                if (ready_i) begin
                    // Occupancy after this pop, counting a same-cycle push.
                    if ((count > (AW + 1)'(1)) || push) begin
                        state_next = S_CT_HI;
                    end else if (tag_pend) begin
                        state_next = S_TAG;
                        widx_next  = 2'd0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_TAG: begin
                valid_o  = 1'b1;
                is_tag_o = 1'b1;
                last_o   = (widx == 2'd3);
                unique case (widx)
                    2'd0: data_o = tag_q[127:96];
                    2'd1: data_o = tag_q[95:64];
                    2'd2: data_o = tag_q[63:32];
                    2'd3: data_o = tag_q[31:0];
                endcase
                if (ready_i) begin
                    if (widx == 2'd3) begin
                        state_next = empty ? S_IDLE : S_CT_HI;
                        widx_next  = 2'd0;
                    end else begin
                        widx_next = widx + 2'd1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_out_collector.sv
// tb_ascon_out_collector
// Directed scenarios against hand-computed word sequences for the ASCON
// output collector.
module tb_ascon_out_collector;

    localparam int DEPTH = 4;

    logic         clock_i;
    logic         reset_i;
    logic         start_i;
    logic [63:0]  cipher_i;
    logic         cipher_valid_i;
    logic [127:0] tag_i;
    logic         end_i;
    logic         ready_i;
    logic [31:0]  data_o;
    logic         valid_o;
    logic         is_tag_o;
    logic         last_o;
    logic         overflow_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    ascon_out_collector #(.DEPTH(DEPTH)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .cipher_i       (cipher_i),
        .cipher_valid_i (cipher_valid_i),
        .tag_i          (tag_i),
        .end_i          (end_i),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .is_tag_o       (is_tag_o),
        .last_o         (last_o),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #1;
        checks++;
        if ({data_o, valid_o, is_tag_o, last_o, overflow_o, busy_o} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b t=%b l=%b o=%b b=%b expected all 0",
                     data_o, valid_o, is_tag_o, last_o, overflow_o, busy_o);
        end
        step();
        step();
        reset_i = 1'b0;
        step();
        checks++;
        if ({valid_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got v=%b b=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_single_block();
        logic [31:0] exp_w [2];
        exp_w[0] = 32'h01234567;
        exp_w[1] = 32'h89ABCDEF;
        ready_i        = 1'b1;
        cipher_i       = 64'h0123456789ABCDEF;
        cipher_valid_i = 1'b1;
        step();
        cipher_valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got v=%b b=%b expected v=0 b=1", valid_o, busy_o);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_w[i] || is_tag_o !== 1'b0 || last_o !== 1'b0) begin
                errors++;
                $display("FAIL single_word%0d got v=%b data=%h t=%b l=%b expected v=1 data=%h t=0 l=0",
                         i, valid_o, data_o, is_tag_o, last_o, exp_w[i]);
            end
            step();
        end
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 32'd0) begin
            errors++;
            $display("FAIL single_done got v=%b b=%b data=%h expected 0 0 0", valid_o, busy_o, data_o);
        end
    endtask

    task automatic test_block_then_tag();
        logic [31:0] exp_w [6];
        logic [5:0]  exp_t;
        logic [5:0]  exp_l;
        exp_w[0] = 32'hDEADBEEF;
        exp_w[1] = 32'hCAFEF00D;
        exp_w[2] = 32'h00112233;
        exp_w[3] = 32'h44556677;
        exp_w[4] = 32'h8899AABB;
        exp_w[5] = 32'hCCDDEEFF;
        exp_t = 6'b111100;
        exp_l = 6'b100000;
        ready_i        = 1'b1;
        cipher_i       = 64'hDEADBEEF_CAFEF00D;
        cipher_valid_i = 1'b1;
        step();
        cipher_valid_i = 1'b0;
        tag_i          = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        end_i          = 1'b1;
        step();
        end_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_w[i] || is_tag_o !== exp_t[i] || last_o !== exp_l[i]) begin
                errors++;
                $display("FAIL tag_seq_word%0d got v=%b data=%h t=%b l=%b expected v=1 data=%h t=%b l=%b",
                         i, valid_o, data_o, is_tag_o, last_o, exp_w[i], exp_t[i], exp_l[i]);
            end
            step();
        end
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tag_seq_done got v=%b b=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i        = 1'b0;
        cipher_i       = 64'h11112222_33334444;
        cipher_valid_i = 1'b1;
        step();
        cipher_valid_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 32'h11112222) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b data=%h expected v=1 data=11112222", i, valid_o, data_o);
            end
            step();
        end
        ready_i = 1'b1;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h11112222) begin
            errors++;
            $display("FAIL stall_release_hi got v=%b data=%h expected v=1 data=11112222", valid_o, data_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h33334444) begin
            errors++;
            $display("FAIL stall_release_lo got v=%b data=%h expected v=1 data=33334444", valid_o, data_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got v=%b expected 0", valid_o);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] blk [DEPTH+1];
        blk[0] = 64'hA0A0A0A0_B0B0B0B0;
        blk[1] = 64'hA1A1A1A1_B1B1B1B1;
        blk[2] = 64'hA2A2A2A2_B2B2B2B2;
        blk[3] = 64'hA3A3A3A3_B3B3B3B3;
        blk[4] = 64'hA4A4A4A4_B4B4B4B4;
        ready_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            cipher_i       = blk[i];
            cipher_valid_i = 1'b1;
            step();
            checks++;
            if (overflow_o !== (i == DEPTH)) begin
                errors++;
                $display("FAIL ovf_after_pulse%0d got %b expected %b", i, overflow_o, (i == DEPTH));
            end
        end
        cipher_valid_i = 1'b0;
        ready_i        = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== (i[0] ? blk[i/2][31:0] : blk[i/2][63:32])) begin
                errors++;
                $display("FAIL ovf_drain_word%0d got v=%b data=%h expected v=1 data=%h",
                         i, valid_o, data_o, (i[0] ? blk[i/2][31:0] : blk[i/2][63:32]));
            end
            step();
        end
        checks++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained got v=%b ovf=%b expected v=0 ovf=1", valid_o, overflow_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_start_clear got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_full_plus_pop();
        logic [63:0] blk [DEPTH+1];
        blk[0] = 64'hC0C0C0C0_D0D0D0D0;
        blk[1] = 64'hC1C1C1C1_D1D1D1D1;
        blk[2] = 64'hC2C2C2C2_D2D2D2D2;
        blk[3] = 64'hC3C3C3C3_D3D3D3D3;
        blk[4] = 64'hC4C4C4C4_D4D4D4D4;
        ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cipher_i       = blk[i];
            cipher_valid_i = 1'b1;
            step();
        end
        cipher_valid_i = 1'b0;
        ready_i        = 1'b1;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hC0C0C0C0) begin
            errors++;
            $display("FAIL fpp_head_hi got v=%b data=%h expected v=1 data=c0c0c0c0", valid_o, data_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hD0D0D0D0) begin
            errors++;
            $display("FAIL fpp_head_lo got v=%b data=%h expected v=1 data=d0d0d0d0", valid_o, data_o);
        end
        cipher_i       = blk[DEPTH];
        cipher_valid_i = 1'b1;
        step();
        cipher_valid_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL fpp_no_overflow got %b expected 0", overflow_o);
        end
        for (int i = 2; i < 2 * (DEPTH + 1); i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== (i[0] ? blk[i/2][31:0] : blk[i/2][63:32])) begin
                errors++;
                $display("FAIL fpp_word%0d got v=%b data=%h expected v=1 data=%h",
                         i, valid_o, data_o, (i[0] ? blk[i/2][31:0] : blk[i/2][63:32]));
            end
            step();
        end
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fpp_done got v=%b b=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_tag();
        ready_i = 1'b1;
        tag_i   = 128'hF0F1F2F3_E4E5E6E7_D8D9DADB_CCCDCECF;
        end_i   = 1'b1;
        step();
        end_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b1 || is_tag_o !== 1'b1 || data_o !== 32'hF0F1F2F3) begin
            errors++;
            $display("FAIL rmt_tag0 got v=%b t=%b data=%h expected v=1 t=1 data=f0f1f2f3",
                     valid_o, is_tag_o, data_o);
        end
        step();
        step();
        checks++;
        if (valid_o !== 1'b1 || is_tag_o !== 1'b1 || last_o !== 1'b0 || data_o !== 32'hD8D9DADB) begin
            errors++;
            $display("FAIL rmt_tag2 got v=%b t=%b l=%b data=%h expected v=1 t=1 l=0 data=d8d9dadb",
                     valid_o, is_tag_o, last_o, data_o);
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if ({data_o, valid_o, is_tag_o, last_o, overflow_o, busy_o} !== 37'd0) begin
            errors++;
            $display("FAIL rmt_async_reset got data=%h v=%b t=%b l=%b o=%b b=%b expected all 0",
                     data_o, valid_o, is_tag_o, last_o, overflow_o, busy_o);
        end
        step();
        reset_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rmt_no_resume got v=%b b=%b expected 0 0", valid_o, busy_o);
        end
        cipher_i       = 64'h5566778899AABBCC;
        cipher_valid_i = 1'b1;
        step();
        cipher_valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b1 || is_tag_o !== 1'b0 || data_o !== 32'h55667788) begin
            errors++;
            $display("FAIL rmt_new_hi got v=%b t=%b data=%h expected v=1 t=0 data=55667788",
                     valid_o, is_tag_o, data_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h99AABBCC) begin
            errors++;
            $display("FAIL rmt_new_lo got v=%b data=%h expected v=1 data=99aabbcc", valid_o, data_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rmt_done got v=%b b=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset_i        = 1'b1;
        start_i        = 1'b0;
        cipher_i       = '0;
        cipher_valid_i = 1'b0;
        tag_i          = '0;
        end_i          = 1'b0;
        ready_i        = 1'b0;
        test_reset();
        test_single_block();
        test_block_then_tag();
        test_backpressure();
        test_overflow();
        test_full_plus_pop();
        test_reset_mid_tag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
